// File: rtl/eval_dma_calc_ctl.sv
// AXI4-Lite control slave for the DMA-fed exp fp32 calc core.
// Optional busy-cycle counter: EVAL_DMA_CALC_CTL_CYCLE_COUNT_EN.
module eval_dma_calc_ctl #(
  parameter int          AXI4L_ADDR_WIDTH = 40,
  parameter int          AXI4L_DATA_WIDTH = 64,
  parameter int          AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH/8,
  parameter int          DMA_ADDR_WIDTH   = 40,
  parameter int          LEN_WIDTH        = 32,
  parameter logic [63:0] CORE_ID          = 64'h527A_0110_0000_0128
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_awaddr,
  input  logic [2:0]                  s_axi4l_awprot,
  input  logic                        s_axi4l_awvalid,
  output logic                        s_axi4l_awready,
  input  logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_wdata,
  input  logic [AXI4L_STRB_WIDTH-1:0] s_axi4l_wstrb,
  input  logic                        s_axi4l_wvalid,
  output logic                        s_axi4l_wready,
  output logic [1:0]                  s_axi4l_bresp,
  output logic                        s_axi4l_bvalid,
  input  logic                        s_axi4l_bready,
  input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_araddr,
  input  logic [2:0]                  s_axi4l_arprot,
  input  logic                        s_axi4l_arvalid,
  output logic                        s_axi4l_arready,
  output logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_rdata,
  output logic [1:0]                  s_axi4l_rresp,
  output logic                        s_axi4l_rvalid,
  input  logic                        s_axi4l_rready,
  output logic                        m_start,
  output logic [DMA_ADDR_WIDTH-1:0]   m_src_addr,
  output logic [DMA_ADDR_WIDTH-1:0]   m_dst_addr,
  output logic [LEN_WIDTH-1:0]        m_len,
  input  logic                        s_done,
  output logic                        irq
);

  localparam int DW = AXI4L_DATA_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nx;

  logic                        aw_held, w_held;
  logic [4:0]                  aw_idx;
  logic [DW-1:0]               wdata_q;
  logic [AXI4L_STRB_WIDTH-1:0] wstrb_q;
  logic                        we;
  logic                        start_req, start_fire, done_fire;

  logic [DMA_ADDR_WIDTH-1:0]   src_q, dst_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic                        irq_en, irq_st, done_sticky;
  logic                        w1c, irq_en_we, irq_en_nx, irq_st_nx;

  logic [4:0]                  ar_idx;
  logic [DW-1:0]               rd_val;
  logic [63:0]                 cycles_rd;
  logic                        unused_bits;

  assign unused_bits = ^{s_axi4l_awprot, s_axi4l_arprot,
                         s_axi4l_awaddr, s_axi4l_araddr,
                         wdata_q, wstrb_q, cycles_rd};

  assign s_axi4l_awready = !aw_held && !s_axi4l_bvalid;
  assign s_axi4l_wready  = !w_held && !s_axi4l_bvalid;
  assign s_axi4l_arready = !s_axi4l_rvalid;
  assign s_axi4l_bresp   = 2'b00;
  assign s_axi4l_rresp   = 2'b00;

  assign we        = aw_held && w_held;
  assign start_req = we && aw_idx == 5'd1 && wstrb_q[0] && wdata_q[0];
  assign w1c       = we && aw_idx == 5'd7 && wstrb_q[0] && wdata_q[0];
  assign irq_en_we = we && aw_idx == 5'd6 && wstrb_q[0];
  assign irq_en_nx = irq_en_we ? wdata_q[0] : irq_en;
  // a completion in the clear cycle must not be lost
  assign irq_st_nx = done_fire | (irq_st & ~w1c);

  always_comb begin
    state_nx   = state;
    start_fire = 1'b0;
    done_fire  = 1'b0;
    unique case (state)
      IDLE: if (start_req) begin
        start_fire = 1'b1;
        state_nx   = BUSY;
      end
      BUSY: if (s_done) begin
        done_fire = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_idx         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      s_axi4l_bvalid <= 1'b0;
    end else begin
      if (we) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (s_axi4l_awvalid && s_axi4l_awready) begin
          aw_held <= 1'b1;
          aw_idx  <= s_axi4l_awaddr[7:3];
        end
        if (s_axi4l_wvalid && s_axi4l_wready) begin
          w_held  <= 1'b1;
          wdata_q <= s_axi4l_wdata;
          wstrb_q <= s_axi4l_wstrb;
        end
      end
      if (we)                  s_axi4l_bvalid <= 1'b1;
      else if (s_axi4l_bready) s_axi4l_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      irq_en      <= 1'b0;
      irq_st      <= 1'b0;
      irq         <= 1'b0;
      done_sticky <= 1'b0;
      m_start     <= 1'b0;
      m_src_addr  <= '0;
      m_dst_addr  <= '0;
      m_len       <= '0;
    end else begin
      irq_en  <= irq_en_nx;
      irq_st  <= irq_st_nx;
      irq     <= irq_st_nx & irq_en_nx;
      m_start <= start_fire;
      // running job uses shadow copies taken at start
      if (start_fire) begin
        m_src_addr  <= src_q;
        m_dst_addr  <= dst_q;
        m_len       <= len_q;
        done_sticky <= 1'b0;
      end else if (done_fire) begin
        done_sticky <= 1'b1;
      end
      for (int i = 0; i < DMA_ADDR_WIDTH/8; i++) begin
        if (we && aw_idx == 5'd3 && wstrb_q[i])
          src_q[i*8 +: 8] <= wdata_q[i*8 +: 8];
        if (we && aw_idx == 5'd4 && wstrb_q[i])
          dst_q[i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
      for (int i = 0; i < LEN_WIDTH/8; i++) begin
        if (we && aw_idx == 5'd5 && wstrb_q[i])
          len_q[i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

`ifdef EVAL_DMA_CALC_CTL_CYCLE_COUNT_EN
  logic [63:0] cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cycles <= '0;
    else if (start_fire)
      cycles <= '0;
    else if (state == BUSY && cycles != '1)
      cycles <= cycles + 64'd1;
  end

  assign cycles_rd = cycles;
`else
  assign cycles_rd = '0;
`endif

  assign ar_idx = s_axi4l_araddr[7:3];

  always_comb begin
    rd_val = '0;
    case (ar_idx)
      5'd0: rd_val = DW'(CORE_ID);
      5'd2: rd_val[1:0] = {done_sticky, state == BUSY};
      5'd3: rd_val[DMA_ADDR_WIDTH-1:0] = src_q;
      5'd4: rd_val[DMA_ADDR_WIDTH-1:0] = dst_q;
      5'd5: rd_val[LEN_WIDTH-1:0] = len_q;
      5'd6: rd_val[0] = irq_en;
      5'd7: rd_val[0] = irq_st;
      5'd8: rd_val = DW'(cycles_rd);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_axi4l_rvalid <= 1'b0;
      s_axi4l_rdata  <= '0;
    end else if (s_axi4l_arvalid && s_axi4l_arready) begin
      s_axi4l_rvalid <= 1'b1;
      s_axi4l_rdata  <= rd_val;
    end else if (s_axi4l_rready) begin
      s_axi4l_rvalid <= 1'b0;
    end
  end

endmodule
